// File: rtl/async_fifo_wr_ctrl.sv
// Write-side controller of the asynchronous FIFO: binary/Gray write pointer,
// read-pointer synchroniser, full/almost-full, fill level and sticky overflow.
module async_fifo_wr_ctrl #(
  parameter int ADDR_W       = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 14
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   rd_ptr_gray_i,
  input  logic              clr_ovf_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [ADDR_W:0]   wr_ptr_gray_o,
  output logic              fifo_full_o,
  output logic              almost_full_o,
  output logic [ADDR_W:0]   wr_level_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] AF_T = (ADDR_W+1)'(AFULL_THRESH);

  logic [SYNC_STAGES-1:0][ADDR_W:0] sync_q;
  logic [ADDR_W:0] rq_gray, rq_bin;
  logic [ADDR_W:0] wr_bin_q, wr_bin_d;
  logic [ADDR_W:0] wr_gray_q, wr_gray_d;
  logic            ovf_q, ovf_d;
  logic            full;

  // Raw asynchronous input lands directly in the first flop.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], rd_ptr_gray_i};
  end

  assign rq_gray = sync_q[SYNC_STAGES-1];

  always_comb begin
    rq_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) rq_bin[i] = ^(rq_gray >> i);
  end

  // Full when pointers match except for the two MSBs of the Gray code.
  assign full = (wr_gray_q == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]});

  // Reset gating keeps the RAM write port quiet while the block is held in reset.
  assign wr_en_o   = wr_en_i & ~full & rst_n;
  assign wr_bin_d  = wr_bin_q + {{ADDR_W{1'b0}}, wr_en_o};
  assign wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
  assign ovf_d     = (wr_en_i & full) | (ovf_q & ~clr_ovf_i);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      ovf_q     <= ovf_d;
    end
  end

  assign wr_addr_o     = wr_bin_q[ADDR_W-1:0];
  assign wr_ptr_gray_o = wr_gray_q;
  assign fifo_full_o   = full;
  assign wr_level_o    = wr_bin_q - rq_bin;
  assign almost_full_o = (wr_level_o >= AF_T);
  assign overflow_o    = ovf_q;

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Bench for async_fifo_wr_ctrl: directed vector table, random traffic against a
// count-based model, wrap sequence and asynchronous reset mid-burst.
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en_i, clr_ovf_i;
  logic [4:0] rd_ptr_gray_i;
  logic       wr_en_o, fifo_full_o, almost_full_o, overflow_o;
  logic [3:0] wr_addr_o;
  logic [4:0] wr_ptr_gray_o, wr_level_o;

  async_fifo_wr_ctrl #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_THRESH(14)) dut (
    .clk_i(clk), .rst_n(rst_n), .wr_en_i(wr_en_i), .rd_ptr_gray_i(rd_ptr_gray_i),
    .clr_ovf_i(clr_ovf_i), .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o),
    .wr_ptr_gray_o(wr_ptr_gray_o), .fifo_full_o(fifo_full_o),
    .almost_full_o(almost_full_o), .wr_level_o(wr_level_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit wr; bit clr; int rd;
    bit e_wen; int e_addr; int e_gray; bit e_full; bit e_af; int e_lvl; bit e_ovf;
  } vec_t;
  vec_t tbl[25];

  int npass = 0, ntot = 0;

  // Model: total writes accepted, read count as seen after synchronisation delay.
  int wcnt, rdc;
  int rq[$];
  bit movf;

  function automatic logic [4:0] g5(input int r);
    int b;
    b = r % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic int mlvl();
    return wcnt - rq[0];
  endfunction

  task automatic model_reset();
    wcnt = 0; movf = 0; rq = '{0, 0};
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic chk_all(input string t, input bit wen, input int addr, input int gray,
                         input bit full, input bit af, input int lvl, input bit ovf);
    chk({t, ".wr_en"}, int'(wr_en_o), int'(wen));
    chk({t, ".addr"},  int'(wr_addr_o), addr);
    chk({t, ".gray"},  int'(wr_ptr_gray_o), gray);
    chk({t, ".full"},  int'(fifo_full_o), int'(full));
    chk({t, ".afull"}, int'(almost_full_o), int'(af));
    chk({t, ".level"}, int'(wr_level_o), lvl);
    chk({t, ".ovf"},   int'(overflow_o), int'(ovf));
  endtask

  task automatic chk_model(input string t);
    bit f;
    f = (mlvl() == 16);
    chk_all(t, wr_en_i & !f, wcnt % 16, int'(g5(wcnt)), f, mlvl() >= 14, mlvl(), movf);
  endtask

  // Inputs change one time unit after the edge; checks sit mid-cycle.
  task automatic drive(input bit w, input bit c, input int r);
    wr_en_i = w; clr_ovf_i = c; rdc = r; rd_ptr_gray_i = g5(r);
    #4;
  endtask

  task automatic tick();
    bit f;
    @(posedge clk);
    f = (mlvl() == 16);
    movf = (wr_en_i & f) | (movf & !clr_ovf_i);
    if (wr_en_i && !f) wcnt++;
    void'(rq.pop_front());
    rq.push_back(rdc);
    #1;
  endtask

  initial begin
    bit seen31, seen_wrap;
    int guard;

    for (int k = 0; k < 16; k++)
      tbl[k] = '{1, 0, 0, 1, k, k ^ (k >> 1), 0, k >= 14, k, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 24, 1, 1, 16, 0};  // blocked write at full
    tbl[17] = '{1, 1, 0, 0, 0, 24, 1, 1, 16, 1};  // set beats clear
    tbl[18] = '{0, 1, 0, 0, 0, 24, 1, 1, 16, 1};
    tbl[19] = '{0, 0, 0, 0, 0, 24, 1, 1, 16, 0};
    tbl[20] = '{1, 0, 1, 0, 0, 24, 1, 1, 16, 0};  // read pointer advances
    tbl[21] = '{1, 0, 1, 0, 0, 24, 1, 1, 16, 1};  // still full one edge later
    tbl[22] = '{1, 0, 1, 1, 0, 24, 0, 1, 15, 1};  // pending write admitted
    tbl[23] = '{0, 1, 1, 0, 1, 25, 1, 1, 16, 1};
    tbl[24] = '{0, 0, 1, 0, 1, 25, 1, 1, 16, 0};

    rst_n = 1'b0; wr_en_i = 1'b1; clr_ovf_i = 1'b0; rdc = 0; rd_ptr_gray_i = '0;
    model_reset();
    #2 chk_all("rst", 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 chk_all("rst_hold", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].clr, tbl[i].rd);
      chk_all($sformatf("vec%0d", i), tbl[i].e_wen, tbl[i].e_addr, tbl[i].e_gray,
              tbl[i].e_full, tbl[i].e_af, tbl[i].e_lvl, tbl[i].e_ovf);
      tick();
    end

    for (int c = 0; c < 400; c++) begin
      int r;
      r = rdc;
      if (r < wcnt && ($urandom_range(99) < ((c < 150) ? 25 : 60))) r++;
      drive($urandom_range(3) != 0, $urandom_range(7) == 0, r);
      chk_model($sformatf("rnd%0d", c));
      tick();
    end

    rst_n = 1'b0; model_reset(); #1 rst_n = 1'b1;
    seen31 = 0; seen_wrap = 0; guard = 0;
    while (wcnt < 40 && guard < 60) begin
      drive(1, 0, (wcnt > 3) ? wcnt - 3 : 0);
      chk_model($sformatf("wrap%0d", guard));
      chk("wrap.level_le5", int'(wr_level_o <= 5), 1);
      if (wr_ptr_gray_o == 5'b10000) seen31 = 1;
      if (seen31 && wr_ptr_gray_o == 5'b00000) seen_wrap = 1;
      tick();
      guard++;
    end
    chk("wrap.writes", wcnt, 40);
    chk("wrap.saw_bin31", int'(seen31), 1);
    chk("wrap.saw_zero", int'(seen_wrap), 1);

    rst_n = 1'b0; model_reset(); #1 rst_n = 1'b1;
    rdc = 0;
    for (int c = 0; c < 9; c++) begin
      drive(1, 0, 0);
      tick();
    end
    drive(1, 0, 0);
    chk_model("burst9");
    rst_n = 1'b0;
    #1 chk_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
    model_reset();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/async_fifo_wr_ctrl.md
Name: async_fifo_wr_ctrl

Overview:
Parametrised write-side controller for the asynchronous FIFO, in the write clock domain. Generalises the fixed 16-entry write controller to 2^ADDR_W entries. Adds Gray-coded pointer exchange, an internal read-pointer synchroniser, a fill level, almost-full, and a sticky overflow flag. Drives the dual-port RAM write port and exports a Gray write pointer for the read-side controller.

Parameters:
ADDR_W, 4, RAM address width; depth = 2^ADDR_W; legal range 2..12.
SYNC_STAGES, 2, flop stages synchronising rd_ptr_gray_i; legal range 2..4.
AFULL_THRESH, 14, level at or above which almost_full_o asserts; legal range 1..2^ADDR_W.

Ports:
clk_i  in  1  write-domain clock.
rst_n  in  1  asynchronous active-low reset.
wr_en_i  in  1  write request.
rd_ptr_gray_i  in  ADDR_W+1  Gray read pointer from the read domain (asynchronous).
clr_ovf_i  in  1  clears overflow_o.
wr_en_o  out  1  qualified RAM write enable.
wr_addr_o  out  ADDR_W  RAM write address.
wr_ptr_gray_o  out  ADDR_W+1  registered Gray write pointer to the read domain.
fifo_full_o  out  1  FIFO full.
almost_full_o  out  1  level >= AFULL_THRESH.
wr_level_o  out  ADDR_W+1  fill level as seen from the write domain, 0..2^ADDR_W.
overflow_o  out  1  sticky: a write was attempted while full.

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_n is asynchronous, active-low.
- Reset: binary pointer wr_bin, wr_ptr_gray_o and all synchroniser flops = 0. overflow_o = 0.
- Reset outputs: fifo_full_o = 0, almost_full_o = 0 (unless AFULL_THRESH = 0, which is illegal), wr_level_o = 0, wr_en_o = 0.
- Pointers: wr_bin is ADDR_W+1 bits. wr_addr_o = wr_bin[ADDR_W-1:0].
- Gray pointer: wr_ptr_gray_o is a register loaded with gray(wr_bin_next), so it always equals gray(wr_bin). It is never driven combinationally.
- Synchroniser: rd_ptr_gray_i passes through a chain of SYNC_STAGES flops to give rq_gray. No logic is allowed before the first flop. A change on the input is visible in rq_gray after exactly SYNC_STAGES rising edges.
- rq_bin = gray-to-binary(rq_gray), implemented as combinational XOR-prefix.
- Full: fifo_full_o = (wr_ptr_gray_o == {~rq_gray[ADDR_W:ADDR_W-1], rq_gray[ADDR_W-2:0]}). This is combinational from registers, so no input-to-output path exists.
- Write qualification: wr_en_o = wr_en_i & ~fifo_full_o, combinational in the same cycle.
- Pointer update: wr_bin increments by 1 on each edge where wr_en_o = 1. It wraps modulo 2^(ADDR_W+1), e.g. 31 -> 0 at ADDR_W = 4.
- Level: wr_level_o = (wr_bin - rq_bin) mod 2^(ADDR_W+1), combinational.
  - It is pessimistic: it overestimates by reads not yet synchronised.
  - It never exceeds 2^ADDR_W.
- almost_full_o = (wr_level_o >= AFULL_THRESH), combinational.
- Overflow: set on an edge where wr_en_i & fifo_full_o. Cleared on an edge where clr_ovf_i = 1. Set wins over a simultaneous clear.
- Simultaneous events: a read-pointer advance arriving in the same cycle as a blocked write does not admit that write. Admission requires full to deassert first.
- Reset mid-operation: all state returns to reset values immediately, independent of the clock. The read domain is reset concurrently at system level.

Test Plan:
(ADDR_W = 4, SYNC_STAGES = 2, AFULL_THRESH = 14 unless stated.)
1. Reset with wr_en_i = 1 and rd_ptr_gray_i = 0 -> required response:
   - During reset: wr_en_o = 0, wr_ptr_gray_o = 00000, wr_level_o = 0, all flags 0.
   - After release: wr_en_o = 1 in the first cycle.
2. 16 consecutive writes with rd_ptr_gray_i = 0 -> required response:
   - almost_full_o rises after the 14th accepted write.
   - fifo_full_o rises after the 16th, with wr_ptr_gray_o = 11000 and wr_level_o = 16.
3. Full, then wr_en_i = 1 -> required response:
   - wr_en_o = 0 and wr_addr_o holds at 0.
   - overflow_o = 1 from the next edge and stays 1.
   - Assert clr_ovf_i with wr_en_i = 1: overflow_o stays 1.
   - Drop wr_en_i and pulse clr_ovf_i: overflow_o = 0.
4. Full, then rd_ptr_gray_i changes 00000 -> 00001 -> required response:
   - fifo_full_o stays 1 for exactly 1 edge after the change, then deasserts after the 2nd edge.
   - wr_level_o = 15.
   - A pending write is accepted in that cycle.
5. 40 writes with the read pointer trailing by 3 entries -> required response:
   - wr_ptr_gray_o passes 10000 (bin 31), then 00000.
   - No false full and no overflow.
   - wr_level_o never exceeds 5.
6. Assert rst_n low mid-burst at level 9 -> required response: all outputs reach their reset values asynchronously, before the next clock edge.
